memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Sequential arbiter that shares the single-port external memory between the instruction-fetch path, the data load/store path and, optionally, a debug/IO requester. It sits between the control unit and the memory address handler on one side and the memory on the other, and runs on the fast clock. It serialises accesses, issues exactly one memory command per transaction, waits out the memory read latency, and returns read data with a per-requester completion pulse. Fixed priority with an anti-starvation counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_WIDTH, 14, memory word-address width
- DATA_WIDTH, 32, memory data width
- READ_LATENCY, 1, edges from command sample to valid mem_rdata (1..7)
- STARVE_LIMIT, 4, consecutive non-fetch grants allowed while fetch_req is pending (1..15)

Ports:
- fast_clock  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- fetch_req  in  1  instruction read request, held until fetch_gnt
- fetch_addr  in  ADDR_WIDTH  instruction address
- fetch_gnt  out  1  one-cycle pulse, command issued
- fetch_done  out  1  one-cycle pulse, rdata valid
- data_req, data_we  in  1 each  load/store request, 1 = store
- data_addr  in  ADDR_WIDTH; data_wdata  in  DATA_WIDTH
- data_gnt, data_done  out  1 each  as for fetch
- dbg_req, dbg_we  in  1 each; dbg_addr  in  ADDR_WIDTH; dbg_wdata  in  DATA_WIDTH
- dbg_gnt, dbg_done  out  1 each
- rdata  out  DATA_WIDTH  read data, valid in the cycle a *_done is high
- mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_we  out  1
- mem_rdata  in  DATA_WIDTH
- busy  out  1  high in any state other than IDLE

The dbg_* ports exist only with MEM_ARB_DEBUG_PORT_EN; see Configuration.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is high, latch the winner's id, addr, we and wdata, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (one cycle): drive mem_addr and mem_wdata from the latch. mem_we = latched we. Pulse the winner's *_gnt. Load the latency counter with READ_LATENCY-1 and go to WAIT. If READ_LATENCY=1 the counter is 0, so go to WAIT and leave on the next edge.
- WAIT: mem_we=0. Decrement the counter. At 0, capture mem_rdata into rdata and go to DONE.
- DONE (one cycle): pulse the winner's *_done. rdata holds its value until the next capture. If a request is pending, arbitrate exactly as in IDLE and go straight to ISSUE. Otherwise go to IDLE.
- Stores follow the same sequence. *_done acknowledges the write, and rdata is don't-care.
- Priority: data > dbg > fetch.
- Starvation counter:
  - Increments on each non-fetch grant while fetch_req is high, saturating at STARVE_LIMIT.
  - When it equals STARVE_LIMIT and fetch_req is high, fetch wins.
  - Clears on any fetch grant, and in any arbitration cycle where fetch_req is low.
- Requests are sampled only in IDLE and DONE. Dropping a req before its gnt is a requester protocol violation; the arbiter ignores it if not sampled.
- Reset (asserted at any time, including mid-transaction):
  - State becomes IDLE and the in-flight transaction is dropped; no *_done is issued for it.
  - All gnt/done outputs, mem_we and busy are 0.
  - mem_addr, mem_wdata and rdata are 0.
  - The starvation counter is 0.

## Timing
- All outputs are registered.
- Request sampled at edge E0 produces: ISSUE in cycle 1 (gnt, mem command); memory samples at E2; mem_rdata valid in cycle 1+READ_LATENCY; captured at the following edge; *_done in cycle 2+READ_LATENCY.
- Back-to-back throughput: one transaction per 2+READ_LATENCY cycles (DONE overlaps the next arbitration).
- At most one *_gnt and at most one *_done are high in any cycle.
- mem_we is high only in ISSUE.

## Configuration
- MEM_ARB_DEBUG_PORT_EN defined: the dbg_* ports and the third requester are present, with priority data > dbg > fetch.
- MEM_ARB_DEBUG_PORT_EN undefined: the dbg_* ports are absent and priority is data > fetch. The starvation counter counts data grants only. Everything else is identical.

## Test plan
- Single fetch, READ_LATENCY=1, memory word 0x0010 = 0x0000BEEF; fetch_req and fetch_addr=0x0010 sampled at E0 -> fetch_gnt in cycle 1, fetch_done in cycle 3 with rdata=0x0000BEEF; busy high in cycles 1-3.
- Store: data_req, data_we=1, addr 0x0020, wdata 0x12345678 -> mem_we high exactly one cycle with mem_addr=0x0020; data_done 2+READ_LATENCY cycles later; a later fetch of 0x0020 returns 0x12345678.
- Simultaneous fetch_req and data_req at E0 -> data granted first; fetch granted in the DONE cycle's arbitration with no IDLE gap.
- Starvation, STARVE_LIMIT=4: data_req held high continuously with fetch_req high -> grant order data, data, data, data, fetch, data...
- READ_LATENCY=3 -> done in cycle 5; reset pulsed during WAIT -> no done, all outputs 0, next request is served normally.
- Debug port (macro defined): dbg_req and fetch_req together -> dbg first; with the macro undefined, the design compiles without dbg_* ports and the remaining tests pass.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: serialises fetch/data(/debug) accesses onto one single-port memory
// Ports: fast_clock/reset (async, active-high); fetch_*, data_*, dbg_* requester handshakes
// (req/addr/we/wdata in, one-cycle gnt at command issue, one-cycle done when rdata is valid);
// mem_addr/mem_wdata/mem_we/mem_rdata to the memory; rdata shared read return; busy = not IDLE.
// Option: define MEM_ARB_DEBUG_PORT_EN to add the dbg_* requester (priority data > dbg > fetch).
module memory_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  fast_clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_done,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_gnt,
  output logic                  data_done,
`ifdef MEM_ARB_DEBUG_PORT_EN
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_done,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
`ifdef MEM_ARB_DEBUG_PORT_EN
  localparam int NR = 3;
`else
  localparam int NR = 2;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                state_q, state_d;
  logic [NR-1:0]         win, win_q, win_d, gnt_q, gnt_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [3:0]            starve_q, starve_d;
  logic                  we_d, mem_we_q, mem_we_d, busy_q, busy_d, any_req, arb;

  always_ff @(posedge fast_clock or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      mem_we_q <= mem_we_d;
      busy_q   <= busy_d;
    end

  // One-hot winner: bit0 fetch, bit1 data, bit2 dbg; a saturated starvation count forces fetch.
  always_comb begin
`ifdef MEM_ARB_DEBUG_PORT_EN
    any_req = fetch_req | data_req | dbg_req;
`else
    any_req = fetch_req | data_req;
`endif
    win = '0;
    if (fetch_req && starve_q == 4'(STARVE_LIMIT)) win[0] = 1'b1;
    else if (data_req) win[1] = 1'b1;
`ifdef MEM_ARB_DEBUG_PORT_EN
    else if (dbg_req) win[2] = 1'b1;
`endif
    else if (fetch_req) win[0] = 1'b1;
  end

  always_comb begin
    arb      = state_q == IDLE || state_q == DONE;
    state_d  = state_q;
    win_d    = win_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    we_d     = 1'b0;
    if (arb) begin
      state_d  = any_req ? ISSUE : IDLE;
      starve_d = (!fetch_req || win[0]) ? '0 : starve_q == 4'(STARVE_LIMIT) ? starve_q : starve_q + 4'd1;
      if (any_req) begin
        win_d   = win;
        addr_d  = win[1] ? data_addr : fetch_addr;
        wdata_d = win[1] ? data_wdata : '0;
        we_d    = win[1] & data_we;
`ifdef MEM_ARB_DEBUG_PORT_EN
        if (win[2]) begin
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          we_d    = dbg_we;
        end
`endif
      end
    end else if (state_q == ISSUE) begin
      state_d = WAIT;
      cnt_d   = 3'(READ_LATENCY - 1);
    end else begin
      state_d = cnt_q == '0 ? DONE : WAIT;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 3'd1;
      rdata_d = cnt_q == '0 ? mem_rdata : rdata_q;
    end
  end

  // Outputs are decoded from the next state so they appear registered in the state they belong to.
  always_comb begin
    gnt_d    = state_d == ISSUE ? win_d : '0;
    done_d   = state_d == DONE ? win_q : '0;
    mem_we_d = state_d == ISSUE && we_d;
    busy_d   = state_d != IDLE;
  end

  assign fetch_gnt  = gnt_q[0];
  assign data_gnt   = gnt_q[1];
  assign fetch_done = done_q[0];
  assign data_done  = done_q[1];
`ifdef MEM_ARB_DEBUG_PORT_EN
  assign dbg_gnt    = gnt_q[2];
  assign dbg_done   = done_q[2];
`endif
  assign rdata      = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed checks of memory_port_arbiter at READ_LATENCY 1 and 3
module tb_memory_port_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic        fetch_req = 0, data_req = 0, data_we = 0;
  logic [13:0] fetch_addr = 0, data_addr = 0;
  logic [31:0] data_wdata = 0;
  logic        fetch_gnt, fetch_done, data_gnt, data_done, mem_we, busy;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [13:0] mem_addr;
`ifdef MEM_ARB_DEBUG_PORT_EN
  logic        dbg_req = 0, dbg_we = 0, dbg_gnt, dbg_done;
  logic [13:0] dbg_addr = 0;
  logic [31:0] dbg_wdata = 0;
`endif

  logic        fetch_req3 = 0;
  logic [13:0] fetch_addr3 = 0, ma3;
  logic        fg3, fd3, dg3, dd3, mwe3, busy3;
  logic [31:0] rdata3, mwd3, mrd3;
`ifdef MEM_ARB_DEBUG_PORT_EN
  logic        bg3, bd3;
`endif

  memory_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u1 (
    .fast_clock(clk), .reset(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_done(data_done),
`ifdef MEM_ARB_DEBUG_PORT_EN
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
`endif
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy));

  memory_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) u3 (
    .fast_clock(clk), .reset(rst),
    .fetch_req(fetch_req3), .fetch_addr(fetch_addr3), .fetch_gnt(fg3), .fetch_done(fd3),
    .data_req(1'b0), .data_we(1'b0), .data_addr(14'h0), .data_wdata(32'h0),
    .data_gnt(dg3), .data_done(dd3),
`ifdef MEM_ARB_DEBUG_PORT_EN
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(14'h0), .dbg_wdata(32'h0),
    .dbg_gnt(bg3), .dbg_done(bd3),
`endif
    .rdata(rdata3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_we(mwe3),
    .mem_rdata(mrd3), .busy(busy3));

  logic [31:0] mem1 [0:16383];
  logic [31:0] mem3 [0:16383];
  logic [31:0] rd1;
  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    if (mem_we) mem1[mem_addr] <= mem_wdata;
    rd1 <= mem1[mem_addr];
    if (mwe3) mem3[ma3] <= mwd3;
    p3[0] <= mem3[ma3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata = rd1;
  assign mrd3 = p3[2];

  int tests = 0, fails = 0, n;
  logic seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem1[14'h10] = 32'h0000BEEF;
    mem3[14'h30] = 32'hCAFE0030;
    mem3[14'h31] = 32'hCAFE0031;
    mem3[14'h32] = 32'hCAFE0032;
    #1;
    chk("rst_ctl", {26'b0, fetch_gnt, fetch_done, data_gnt, data_done, mem_we, busy}, 0);
    chk("rst_addr", {18'b0, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    fetch_req = 1; fetch_addr = 14'h10;
    tick;
    chk("f_gnt_c1", {31'b0, fetch_gnt}, 1);
    chk("f_busy_c1", {31'b0, busy}, 1);
    chk("f_addr_c1", {18'b0, mem_addr}, 32'h10);
    fetch_req = 0;
    tick;
    chk("f_c2", {29'b0, fetch_gnt, fetch_done, busy}, 1);
    tick;
    chk("f_done_c3", {30'b0, fetch_done, busy}, 3);
    chk("f_rdata", rdata, 32'h0000BEEF);
    tick;
    chk("f_idle_c4", {30'b0, fetch_done, busy}, 0);

    data_req = 1; data_we = 1; data_addr = 14'h20; data_wdata = 32'h12345678;
    tick;
    chk("st_gnt", {30'b0, data_gnt, mem_we}, 3);
    chk("st_addr", {18'b0, mem_addr}, 32'h20);
    chk("st_wdata", mem_wdata, 32'h12345678);
    data_req = 0; data_we = 0;
    tick;
    chk("st_we_c2", {30'b0, mem_we, data_done}, 0);
    tick;
    chk("st_done_c3", {30'b0, data_done, mem_we}, 2);
    tick;
    fetch_req = 1; fetch_addr = 14'h20;
    tick;
    fetch_req = 0;
    repeat (2) tick;
    chk("st_rb_done", {31'b0, fetch_done}, 1);
    chk("st_rb_data", rdata, 32'h12345678);
    tick;

    fetch_req = 1; fetch_addr = 14'h20; data_req = 1; data_addr = 14'h10;
    tick;
    chk("sim_c1", {30'b0, data_gnt, fetch_gnt}, 2);
    data_req = 0;
    repeat (2) tick;
    chk("sim_c3_done", {30'b0, data_done, busy}, 3);
    chk("sim_c3_rdata", rdata, 32'h0000BEEF);
    tick;
    chk("sim_c4_fgnt", {29'b0, fetch_gnt, data_gnt, busy}, 5);
    fetch_req = 0;
    repeat (2) tick;
    chk("sim_c6_done", {31'b0, fetch_done}, 1);
    chk("sim_c6_rdata", rdata, 32'h12345678);
    tick;
    chk("sim_idle", {31'b0, busy}, 0);

    fetch_req = 1; fetch_addr = 14'h10; data_req = 1; data_we = 0; data_addr = 14'h20;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin tick; n++; end while (!(data_gnt || fetch_gnt) && n < 12);
      chk($sformatf("starve_gap%0d", g), n, g == 0 ? 1 : 3);
      chk($sformatf("starve_who%0d", g), {30'b0, fetch_gnt, data_gnt}, g == 4 ? 2 : 1);
      if (fetch_gnt) fetch_req = 0;
    end
    data_req = 0;
    n = 0;
    do begin tick; n++; end while (busy && n < 12);
    chk("starve_idle", {31'b0, busy}, 0);

    fetch_req3 = 1; fetch_addr3 = 14'h30;
    tick;
    chk("rl3_gnt", {31'b0, fg3}, 1);
    fetch_req3 = 0;
    n = 1;
    do begin tick; n++; end while (!fd3 && n < 12);
    chk("rl3_done_cyc", n, 5);
    chk("rl3_rdata", rdata3, 32'hCAFE0030);
    tick;

    fetch_req3 = 1; fetch_addr3 = 14'h31;
    tick;
    fetch_req3 = 0;
    repeat (2) tick;
    chk("rl3_wait_busy", {31'b0, busy3}, 1);
    rst = 1;
    #1;
    chk("rl3_rst_ctl", {28'b0, fg3, fd3, mwe3, busy3}, 0);
    chk("rl3_rst_addr", {18'b0, ma3}, 0);
    chk("rl3_rst_rdata", rdata3, 0);
    @(posedge clk);
    #1 rst = 0;
    seen = 0;
    repeat (6) begin tick; seen |= fd3 | fg3 | busy3; end
    chk("rl3_no_done", {31'b0, seen}, 0);
    fetch_req3 = 1; fetch_addr3 = 14'h32;
    tick;
    chk("rl3_post_gnt", {31'b0, fg3}, 1);
    fetch_req3 = 0;
    n = 1;
    do begin tick; n++; end while (!fd3 && n < 12);
    chk("rl3_post_cyc", n, 5);
    chk("rl3_post_rdata", rdata3, 32'hCAFE0032);
    tick;

`ifdef MEM_ARB_DEBUG_PORT_EN
    dbg_req = 1; dbg_addr = 14'h10; fetch_req = 1; fetch_addr = 14'h20;
    tick;
    chk("dbg_first", {30'b0, dbg_gnt, fetch_gnt}, 2);
    dbg_req = 0;
    repeat (2) tick;
    chk("dbg_done", {31'b0, dbg_done}, 1);
    chk("dbg_rdata", rdata, 32'h0000BEEF);
    tick;
    chk("dbg_then_fetch", {30'b0, dbg_gnt, fetch_gnt}, 1);
    fetch_req = 0;
    repeat (3) tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
